// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    // Counter must hold values 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix step: retires BITS_PER_CYCLE bits of a shift-add multiply
// (LSB first) or a restoring divide (MSB first).
module muldiv_step #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 div_i,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [WIDTH-1:0]     rem_i,
    input  logic [WIDTH-1:0]     opb_i,
    output logic [2*WIDTH-1:0]   acc_o,
    output logic [WIDTH-1:0]     rem_o
);

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide: acc[WIDTH-1:0] shifts dividend bits out and quotient bits in.
    always_comb begin
        logic [2*WIDTH-1:0] p;
        logic [WIDTH-1:0]   r;
        logic [WIDTH:0]     sh;
        logic [WIDTH:0]     t;
        logic [WIDTH:0]     sum;
        p   = acc_i;
        r   = rem_i;
        sh  = '0;
        t   = '0;
        sum = '0;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            if (div_i) begin
                sh = {r, p[WIDTH-1]};
                t  = sh - {1'b0, opb_i};
                if (!t[WIDTH]) begin
                    r = t[WIDTH-1:0];
                    p[WIDTH-1:0] = {p[WIDTH-2:0], 1'b1};
                end else begin
                    r = sh[WIDTH-1:0];
                    p[WIDTH-1:0] = {p[WIDTH-2:0], 1'b0};
                end
            end else begin
                sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, opb_i} : {(WIDTH+1){1'b0}});
                p   = {sum, p[WIDTH-1:1]};
            end
        end
        acc_o = p;
        rem_o = r;
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers; works on
// magnitudes and applies the result signs in a final FIX cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             kill_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = cnt_width(N);

    generate
        if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4) ||
            (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_param
            $error("muldiv_unit: BITS_PER_CYCLE must be 1, 2 or 4 and divide WIDTH");
        end
    endgenerate

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q, acc_nx;
    logic [WIDTH-1:0]   rem_q, rem_nx, opb_q, hi_q, lo_q;
    logic               div_q, negq_q, negr_q, done_q;

    logic               is_md, is_signed, is_div_op, accept, mt_wr, fix_wr, sa, sb;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rmd;

    assign is_md     = (op_i == OP_MULT) || (op_i == OP_MULTU) || (op_i == OP_DIV) || (op_i == OP_DIVU);
    assign is_signed = (op_i == OP_MULT) || (op_i == OP_DIV);
    assign is_div_op = (op_i == OP_DIV)  || (op_i == OP_DIVU);
    assign accept    = (state_q == ST_IDLE) && start_i && !kill_i && is_md;
    assign mt_wr     = (state_q == ST_IDLE) && start_i && !kill_i &&
                       ((op_i == OP_MTHI) || (op_i == OP_MTLO));
    assign fix_wr    = (state_q == ST_FIX) && !kill_i;

    assign sa    = is_signed & a_i[WIDTH-1];
    assign sb    = is_signed & b_i[WIDTH-1];
    assign abs_a = sa ? -a_i : a_i;
    assign abs_b = sb ? -b_i : b_i;

    muldiv_step #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .div_i (div_q),
        .acc_i (acc_q),
        .rem_i (rem_q),
        .opb_i (opb_q),
        .acc_o (acc_nx),
        .rem_o (rem_nx)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = ST_ITER;
            ST_ITER: begin
                if (kill_i)                  state_d = ST_IDLE;
                else if (cnt_q == CW'(1))    state_d = ST_FIX;
            end
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q != ST_IDLE);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            rem_q  <= '0;
            opb_q  <= '0;
            div_q  <= 1'b0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
        end else if (accept) begin
            cnt_q  <= CW'(N);
            acc_q  <= {{WIDTH{1'b0}}, abs_a};
            rem_q  <= '0;
            opb_q  <= abs_b;
            div_q  <= is_div_op;
            negq_q <= sa ^ sb;
            negr_q <= sa;
        end else if (state_q == ST_ITER) begin
            if (kill_i) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q - 1'b1;
                acc_q <= acc_nx;
                rem_q <= rem_nx;
            end
        end
    end

    // Divide by zero leaves the remainder equal to |a|, so only LO needs forcing.
    assign prod = negq_q ? -acc_q : acc_q;
    assign quo  = (opb_q == '0) ? '1 : (negq_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    assign rmd  = negr_q ? -rem_q : rem_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= fix_wr;
            if (fix_wr) begin
                if (div_q) begin
                    hi_q <= rmd;
                    lo_q <= quo;
                end else begin
                    hi_q <= prod[2*WIDTH-1:WIDTH];
                    lo_q <= prod[WIDTH-1:0];
                end
            end else if (mt_wr) begin
                if (op_i == OP_MTHI) hi_q <= a_i;
                else                 lo_q <= a_i;
            end
        end
    end

    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed plan vectors plus random ops against a
// 64-bit arithmetic reference; a BITS_PER_CYCLE=4 copy runs alongside.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst, start, kill;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done, busy4, done4;
    logic [31:0] hi, lo, hi4, lo4;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
        .clk_i(clk), .reset_i(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
        .kill_i(kill), .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo));

    muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
        .clk_i(clk), .reset_i(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
        .kill_i(kill), .busy_o(busy4), .done_o(done4), .hi_o(hi4), .lo_o(lo4));

    // Reference: {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'h0, x};
        uy = {32'h0, y};
        case (o)
            3'b000: return 64'(sx * sy);
            3'b001: return ux * uy;
            3'b010: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            3'b011: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            default: return 64'h0;
        endcase
    endfunction

    // Present a request for exactly one edge; returns #1 after that edge.
    task automatic go(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output logic [63:0] res, output int lat, output int bcnt,
                          output logic [63:0] res4, output int lat4);
        go(o, x, y);
        bcnt = busy ? 1 : 0;
        lat  = 0;
        lat4 = -1;
        res4 = '0;
        while (!done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bcnt++;
            if (done4 && lat4 < 0) begin lat4 = lat; res4 = {hi4, lo4}; end
        end
        res = {hi, lo};
    endtask

    task automatic test_reset;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", done); end
        total++; if ({hi, lo} !== 64'h0) begin bad++; $display("FAIL reset_hilo got %h want 0", {hi, lo}); end
        total++; if ({busy4, hi4, lo4} !== 65'h0) begin bad++; $display("FAIL reset_dut4 got %h want 0", {busy4, hi4, lo4}); end
    endtask

    task automatic test_multu;
        logic [63:0] r, r4; int lat, bc, lat4;
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, bc, r4, lat4);
        total++; if (r !== 64'hFFFF_FFFE_0000_0001) begin bad++; $display("FAIL multu_res got %h want fffffffe00000001", r); end
        total++; if (lat !== 33) begin bad++; $display("FAIL multu_lat got %0d want 33", lat); end
        total++; if (bc !== 33) begin bad++; $display("FAIL multu_busy got %0d want 33", bc); end
        @(posedge clk); #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL done_pulse got %b want 0", done); end
    endtask

    task automatic test_mult_signed;
        logic [63:0] r, r4; int lat, bc, lat4;
        run_op(3'b000, 32'hFFFF_FFFD, 32'd7, r, lat, bc, r4, lat4);
        total++; if (r !== 64'hFFFF_FFFF_FFFF_FFEB) begin bad++; $display("FAIL mult_res got %h want ffffffffffffffeb", r); end
        total++; if (r4 !== 64'hFFFF_FFFF_FFFF_FFEB) begin bad++; $display("FAIL mult4_res got %h want ffffffffffffffeb", r4); end
        total++; if (lat4 !== 9) begin bad++; $display("FAIL mult4_lat got %0d want 9", lat4); end
    endtask

    task automatic test_divide;
        logic [63:0] r, r4; int lat, bc, lat4;
        run_op(3'b010, 32'hFFFF_FFF9, 32'd2, r, lat, bc, r4, lat4);
        total++; if (r !== 64'hFFFF_FFFF_FFFF_FFFD) begin bad++; $display("FAIL div_neg got %h want ffffffff_fffffffd", r); end
        run_op(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, bc, r4, lat4);
        total++; if (r !== 64'h8000_0000_0000_0000) begin bad++; $display("FAIL divu_big got %h want 80000000_00000000", r); end
        run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, bc, r4, lat4);
        total++; if (r !== 64'h0000_0000_8000_0000) begin bad++; $display("FAIL div_ovf got %h want 00000000_80000000", r); end
        total++; if (r4 !== 64'h0000_0000_8000_0000) begin bad++; $display("FAIL div4_ovf got %h want 00000000_80000000", r4); end
        run_op(3'b011, 32'h1234, 32'h0, r, lat, bc, r4, lat4);
        total++; if (r !== 64'h0000_1234_FFFF_FFFF) begin bad++; $display("FAIL divu_zero got %h want 00001234_ffffffff", r); end
        total++; if (lat !== 33) begin bad++; $display("FAIL divz_lat got %0d want 33", lat); end
        run_op(3'b010, 32'hFFFF_FFF0, 32'h0, r, lat, bc, r4, lat4);
        total++; if (r !== 64'hFFFF_FFF0_FFFF_FFFF) begin bad++; $display("FAIL div_zero got %h want fffffff0_ffffffff", r); end
    endtask

    task automatic test_mt_kill;
        int cyc; bit saw_done, saw_busy;
        saw_busy = 0;
        go(3'b100, 32'hAAAA_0000, 32'h0);
        saw_busy |= busy;
        total++; if (hi !== 32'hAAAA_0000) begin bad++; $display("FAIL mthi got %h want aaaa0000", hi); end
        go(3'b101, 32'h0000_5555, 32'h0);
        saw_busy |= busy;
        total++; if (lo !== 32'h0000_5555) begin bad++; $display("FAIL mtlo got %h want 00005555", lo); end
        total++; if (saw_busy || done) begin bad++; $display("FAIL mt_busy got busy=%b done=%b want 0", saw_busy, done); end
        go(3'b001, 32'd3, 32'd5);
        cyc = 0;
        saw_done = 0;
        while (cyc < 10) begin
            if (cyc == 4) begin start = 1'b1; op = 3'b100; a = 32'hDEAD_BEEF; end
            if (cyc == 9) kill = 1'b1;
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            kill  = 1'b0;
            saw_done |= done;
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL kill_busy got %b want 0", busy); end
        repeat (30) begin @(posedge clk); #1; saw_done |= done; end
        total++; if (saw_done) begin bad++; $display("FAIL kill_done got 1 want 0"); end
        total++; if ({hi, lo} !== 64'hAAAA_0000_0000_5555) begin bad++; $display("FAIL kill_hilo got %h want aaaa0000_00005555", {hi, lo}); end
    endtask

    task automatic test_kill_fix;
        int lat; bit saw_done;
        logic [63:0] prev;
        prev = {hi, lo};
        go(3'b001, 32'h10, 32'h10);
        lat = 0;
        while (lat < 32) begin @(posedge clk); #1; lat++; end
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        saw_done = done;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL killfix_busy got %b want 0", busy); end
        repeat (5) begin @(posedge clk); #1; saw_done |= done; end
        total++; if (saw_done) begin bad++; $display("FAIL killfix_done got 1 want 0"); end
        total++; if ({hi, lo} !== prev) begin bad++; $display("FAIL killfix_hilo got %h want %h", {hi, lo}, prev); end
    endtask

    task automatic test_back_to_back;
        int lat;
        go(3'b001, 32'd100, 32'd200);
        lat = 0;
        while (!done && lat < 200) begin @(posedge clk); #1; lat++; end
        total++; if ({hi, lo} !== 64'd20000) begin bad++; $display("FAIL b2b_first got %h want %h", {hi, lo}, 64'd20000); end
        go(3'b011, 32'd1000, 32'd7);
        lat = 0;
        while (!done && lat < 200) begin @(posedge clk); #1; lat++; end
        total++; if (lat !== 33) begin bad++; $display("FAIL b2b_lat got %0d want 33", lat); end
        total++; if ({hi, lo} !== {32'd6, 32'd142}) begin bad++; $display("FAIL b2b_second got %h want %h", {hi, lo}, {32'd6, 32'd142}); end
    endtask

    task automatic test_async_reset;
        logic [63:0] r, r4; int lat, bc, lat4, cyc;
        go(3'b100, 32'h1111_2222, 32'h0);
        go(3'b001, 32'd9, 32'd9);
        cyc = 0;
        while (cyc < 12) begin @(posedge clk); #1; cyc++; end
        #3 rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy got %b want 0", busy); end
        total++; if ({hi, lo} !== 64'h0) begin bad++; $display("FAIL arst_hilo got %h want 0", {hi, lo}); end
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(3'b001, 32'd6, 32'd7, r, lat, bc, r4, lat4);
        total++; if (r !== 64'd42) begin bad++; $display("FAIL arst_after got %h want 42", r); end
    endtask

    task automatic test_random;
        logic [63:0] r, r4, exp, prev; int lat, bc, lat4;
        logic [2:0] o; logic [31:0] x, y;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 3));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 4))
                0: y = 32'h0;
                1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                2: begin x = 32'($urandom_range(0, 300)); y = 32'($urandom_range(1, 17)); end
                3: y = 32'($signed(-$urandom_range(1, 9)));
                default: ;
            endcase
            exp = model(o, x, y);
            run_op(o, x, y, r, lat, bc, r4, lat4);
            total++; if (r !== exp) begin bad++; $display("FAIL rand_res op=%0d a=%h b=%h got %h want %h", o, x, y, r, exp); end
            total++; if (r4 !== exp) begin bad++; $display("FAIL rand_res4 op=%0d a=%h b=%h got %h want %h", o, x, y, r4, exp); end
            total++; if (lat !== 33 || lat4 !== 9) begin bad++; $display("FAIL rand_lat got %0d/%0d want 33/9", lat, lat4); end
            if (i % 8 == 0) begin
                prev = {hi, lo};
                go(3'($urandom_range(6, 7)), $urandom, $urandom);
                total++; if ({busy, hi, lo} !== {1'b0, prev}) begin bad++; $display("FAIL invalid_op got %h want %h", {busy, hi, lo}, {1'b0, prev}); end
            end
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; kill = 1'b0; op = 3'b0; a = '0; b = '0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        rst = 1'b0;
        test_multu;
        test_mult_signed;
        test_divide;
        test_mt_kill;
        test_kill_fix;
        test_back_to_back;
        test_async_reset;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with HI/LO registers. It extends the combinational ALU with MIPS mult, multu, div, divu, mthi and mtlo.
- Sits beside the ALU in the execute stage.
- The pipeline stalls on busy; it reads hi/lo for mfhi/mflo.
- Width and radix (bits retired per cycle) are parametrised.

Parameters:
- WIDTH, 32: operand width; HI and LO are each WIDTH bits.
- BITS_PER_CYCLE, 1: quotient/product bits retired per iteration. Legal values are 1, 2 and 4; WIDTH must be a multiple of it (elaboration-time check, $error otherwise).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request valid; sampled only when busy=0.
- op  in  3  operation: MULT=000, MULTU=001, DIV=010, DIVU=011, MTHI=100, MTLO=101; others are no-ops.
- a  in  WIDTH  operand A (multiplicand/dividend; mthi/mtlo data).
- b  in  WIDTH  operand B (multiplier/divisor).
- kill  in  1  abort: flush of the issuing instruction.
- busy  out  1  operation in flight; the pipeline must stall mfhi/mflo/new muldiv.
- done  out  1  one-cycle pulse when HI/LO are updated by mult/div.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (async, active-high): state=IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0. Takes effect immediately, including mid-operation.
- States: IDLE, ITER, FIX. N = WIDTH/BITS_PER_CYCLE.
- IDLE, start=1, kill=0, op in mult/div (accept edge E0):
  - Capture a and b.
  - Signed ops capture absolute values plus result-sign flags (quotient sign = sa^sb; remainder sign = sa).
  - Clear the accumulator, load counter=N, go to ITER, busy=1.
- IDLE, start=1, kill=0, op=MTHI/MTLO: write hi (or lo) with a at that edge. busy stays 0 and done stays 0.
- IDLE, start=1, kill=1: request ignored.
- Invalid op: ignored.
- ITER:
  - Each edge retires BITS_PER_CYCLE bits.
  - Multiply: shift-add, LSB first, into a 2*WIDTH accumulator.
  - Divide: restoring, MSB first, with a WIDTH+1-bit partial remainder.
  - Counter decrements; at counter=1 go to FIX.
- FIX (edge E_{N+1}):
  - Apply sign correction.
  - Multiply: hi = product[2W-1:W], lo = product[W-1:0].
  - Divide: lo = quotient, hi = remainder.
  - Set done=1 for exactly one cycle, busy=0, return to IDLE.
- Latency: busy high for N+1 cycles. done is visible N+1 cycles after the accept edge (33 for 32/1).
- Back-to-back: start may be accepted in the cycle done=1, since busy=0 then.
- start while busy=1: ignored, with no queuing. The pipeline holds the instruction.
- kill while busy=1: return to IDLE at the next edge. busy=0, no done, hi/lo keep their prior values.
- kill in the FIX cycle: kill wins; no write, no done.
- Divide by zero: lo = all ones, hi = captured a. Takes the normal latency with no exception.
- Signed overflow (MIN / -1): lo = MIN, hi = 0.
- Unsigned divide never overflows.
- hi and lo change only at FIX, at an mthi/mtlo edge, or on reset.

Decomposition:
- Package muldiv_pkg holds:
  - the op encoding constants (OP_MULT..OP_MTLO);
  - the state encoding (IDLE/ITER/FIX);
  - a function for the counter width, clog2(N+1).
- Sub-module muldiv_step (combinational): one BITS_PER_CYCLE-wide radix step for both multiply and divide. It is instantiated once in muldiv_unit.

Test Plan (WIDTH=32, BITS_PER_CYCLE=1 unless noted):
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done 33 cycles after accept; busy high 33 cycles.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Repeat with BITS_PER_CYCLE=4 -> same result, done 9 cycles after accept.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=0x80000000, b=0xFFFFFFFF -> lo=0, hi=0x80000000.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234.
- MTHI a=0xAAAA0000 then MTLO a=0x5555 -> hi/lo updated on the edge, busy never high. Then MULTU 3*5 with kill at cycle 10 -> busy low next cycle, hi=0xAAAA0000, lo=0x5555, no done. A start pulsed at cycle 5 while busy is ignored.
- MULTU in flight, assert reset asynchronously mid-cycle at cycle 12 -> busy=0, hi=lo=0 immediately without waiting for an edge. After release, a fresh MULTU 6*7 gives lo=42, hi=0.
